// File: rtl/gameover_rle_if.sv
// Run-entry handshake between the asset loader (master) and the RLE loader (slave).
interface gameover_rle_if #(
    parameter int unsigned COLOR_W = 12,
    parameter int unsigned LEN_W   = 10
);
    logic               run_valid;
    logic               run_ready;
    logic [COLOR_W-1:0] run_color;
    logic [LEN_W-1:0]   run_len;

    modport master (output run_valid, run_color, run_len, input run_ready);
    modport slave  (input run_valid, run_color, run_len, output run_ready);
endinterface

// File: rtl/gameover_rle_loader.sv
// Expands {color, length} runs into sequential sprite-RAM writes covering a
// ROW x COL image, then pulses done once the last pixel has been written.
module gameover_rle_loader #(
    parameter int unsigned COLOR_W = 12,
    parameter int unsigned ROW_W   = 4,
    parameter int unsigned COL_W   = 5,
    parameter int unsigned LEN_W   = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    gameover_rle_if.slave      run,
    output logic               wr_en,
    output logic [ROW_W-1:0]   wr_row,
    output logic [COL_W-1:0]   wr_col,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  addr, addr_d;
    logic [LEN_W-1:0]   remain, remain_d;
    logic [COLOR_W-1:0] color, color_d;
    logic               err_d;

    // State, datapath and state-decoded strobes; strobes register the next state
    // so they are aligned with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            remain        <= '0;
            color         <= '0;
            err           <= 1'b0;
            run.run_ready <= 1'b0;
            wr_en         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            addr          <= addr_d;
            remain        <= remain_d;
            color         <= color_d;
            err           <= err_d;
            run.run_ready <= (state_d == ACCEPT);
            wr_en         <= (state_d == WRITE);
            busy          <= (state_d != IDLE);
            done          <= (state_d == DONE);
        end
    end

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d  = state;
        addr_d   = addr;
        remain_d = remain;
        color_d  = color;
        err_d    = err;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        err_d   = 1'b0;
                        state_d = ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (run.run_valid && run.run_ready && (run.run_len != '0)) begin
                        color_d  = run.run_color;
                        remain_d = run.run_len;
                        state_d  = WRITE;
                    end
                end
                WRITE: begin
                    addr_d   = addr + ADDR_W'(1);
                    remain_d = remain - LEN_W'(1);
                    if (addr == ADDR_LAST) begin
                        state_d = DONE;
                        if (remain > LEN_W'(1)) err_d = 1'b1;
                    end else if (remain == LEN_W'(1)) begin
                        state_d = ACCEPT;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_row  = addr[ADDR_W-1:COL_W];
    assign wr_col  = addr[COL_W-1:0];
    assign wr_data = color;
endmodule

// File: tb/tb_gameover_rle_loader.sv
// Scoreboard bench for gameover_rle_loader: expected writes are queued at each
// handshake and matched against every observed RAM write.
module tb_gameover_rle_loader;
    localparam int unsigned NPIX = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_en, busy, done, err;
    logic [3:0]  wr_row;
    logic [4:0]  wr_col;
    logic [11:0] wr_data;

    gameover_rle_if #(.COLOR_W(12), .LEN_W(10)) bus ();

    gameover_rle_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .run     (bus),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hs_cyc = -1;
    int          ptr = 0;
    logic        exp_err = 1'b0;
    logic [20:0] exp_q[$];
    logic [11:0] ram [NPIX];
    logic [11:0] exp_img [NPIX];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && wr_en) ram[{wr_row, wr_col}] <= wr_data;
    end

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {11'd0, wr_row, wr_col, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'({wr_row, wr_col}), 32'(e[20:12]));
                    check("write_data", 32'(wr_data), 32'(e[11:0]));
                end
                if (bus.run_ready) check("write_in_accept", 32'(bus.run_ready), 32'd0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ptr = 0;
        exp_err = 1'b0;
        done_cnt = 0;
        hs_cyc = -1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(bus.run_ready), 32'd1);
    endtask

    // Offer one run (after a random gap) and queue the writes it should produce.
    task automatic send_run(input logic [11:0] c, input int len, input int max_gap, input int push_max);
        int gap, t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) @(negedge clk);
        bus.run_valid = 1'b1;
        bus.run_color = c;
        bus.run_len   = 10'(len);
        t = 0;
        while (!bus.run_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.run_ready) begin
            check("ready_timeout", 32'(bus.run_ready), 32'd1);
        end else begin
            if (hs_cyc < 0) hs_cyc = cyc;
            for (int i = 0; i < len; i++) begin
                if (ptr < int'(NPIX)) begin
                    if (i < push_max) exp_q.push_back({9'(ptr), c});
                    exp_img[ptr] = c;
                    ptr++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.run_valid = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic ram_dump(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < int'(NPIX); i++) if (ram[i] !== exp_img[i]) mism++;
        check({tag, "_ram_dump"}, 32'(mism), 32'd0);
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, bus.run_ready, wr_en, wr_row, wr_col, wr_data, busy, done, err};
    endfunction

    initial begin
        int rem, len;
        logic [11:0] c;
        bus.run_valid = 1'b0;
        bus.run_color = '0;
        bus.run_len   = '0;
        #3;
        check("reset_outputs", outs(), 32'd0);
        #20 reset_n = 1'b1;

        // Two half-image runs with back-to-back handshakes.
        do_start();
        send_run(12'h0F0, 256, 0, 1000);
        send_run(12'h000, 256, 0, 1000);
        finish_load("two_runs");
        check("two_runs_latency", 32'(done_cyc - hs_cyc), 32'd514);
        ram_dump("two_runs");

        // Full sprite run list with random valid gaps.
        do_start();
        rem = int'(NPIX);
        c = 12'h0F0;
        while (rem > 0) begin
            len = int'($urandom_range(1, 48));
            if (len > rem) len = rem;
            send_run(c, len, 3, 1000);
            rem -= len;
            c = (c == 12'h0F0) ? 12'h000 : 12'h0F0;
        end
        finish_load("sprite");
        ram_dump("sprite");

        // Zero-length run in the middle of the stream.
        do_start();
        send_run(12'h0F0, 300, 1, 1000);
        send_run(12'hFFF, 0, 1, 1000);
        send_run(12'h000, 212, 1, 1000);
        finish_load("zero_run");
        ram_dump("zero_run");

        // Overflowing second run.
        do_start();
        send_run(12'h0F0, 500, 0, 1000);
        send_run(12'h000, 100, 0, 1000);
        finish_load("overflow");
        ram_dump("overflow");
        check("overflow_err_set", 32'(err), 32'd1);
        do_start();
        check("err_cleared_on_start", 32'(err), 32'd0);

        // Abort at the 100th pixel of a 256-pixel run.
        send_run(12'h123, 256, 0, 100);
        repeat (99) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(bus.run_ready), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        do_start();
        send_run(12'hABC, 512, 0, 1000);
        finish_load("after_abort");
        ram_dump("after_abort");

        // Asynchronous reset in the middle of a write burst.
        do_start();
        send_run(12'h456, 256, 0, 50);
        repeat (49) @(negedge clk);
        #3 reset_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("start_in_reset", 32'(busy), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), 32'd0);
        do_start();
        send_run(12'h0F0, 200, 1, 1000);
        send_run(12'h00F, 312, 1, 1000);
        finish_load("after_reset");
        ram_dump("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gameover_rle_loader.md
# gameover_rle_loader

Run-length decoder that writes a full 16×32, 12-bit sprite image into a sprite RAM one pixel per clock. It is the write-side counterpart of the sprite ROM read path. Pixel address is the concatenation {row, col}. The block accepts a stream of {color, length} runs over a valid/ready handshake. It expands each run into sequential RAM writes from address 0 to 511, then pulses `done`. It sits between the asset loader (UART/boot-ROM run source) and the dual-port sprite RAM that the pixel generator reads.

## Interface

- COLOR_W, 12, pixel color width ({R,G,B} 4 bits each)
- ROW_W, 4, row address width
- COL_W, 5, column address width
- LEN_W, 10, run-length field width
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin loading an image; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- run_valid  in  1  run entry present
- run_ready  out  1  block accepts run entry this cycle
- run_color  in  COLOR_W  color of run
- run_len  in  LEN_W  pixel count of run; 0 is legal and produces no writes
- wr_en  out  1  RAM write strobe
- wr_row  out  ROW_W  RAM write row
- wr_col  out  COL_W  RAM write column
- wr_data  out  COLOR_W  RAM write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when pixel 511 has been written
- err  out  1  sticky overflow flag; cleared on accepted `start`

## Operation

- Total pixels N = 2^(ROW_W+COL_W) = 512. Linear address `addr` has ROW_W+COL_W bits. `wr_row` = addr[MSBs], `wr_col` = addr[LSBs].
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: `start` is high, so `addr`←0, `err`←0, next state ACCEPT. `run_*` inputs are ignored.
- ACCEPT: `run_ready`=1. A handshake occurs when `run_valid`&`run_ready`.
  - On handshake with run_len=0: the run is consumed, with no write. Stay in ACCEPT.
  - On handshake with run_len>0: `color`←run_color, `remain`←run_len, next state WRITE.
- WRITE: `run_ready`=0, `wr_en`=1, `wr_data`=color, address=addr. Each cycle `addr`++ and `remain`--.
  - If addr==N-1 this cycle: next state DONE. If `remain`>1 at the same time, set `err` (run overflows the image; excess pixels are discarded, with no wrap to 0).
  - Else if `remain`==1: next state ACCEPT.
  - Else: stay in WRITE.
- DONE: `done`=1 for exactly one cycle, next state IDLE.
- `abort` takes priority over all transitions in every state. The next state is IDLE and `wr_en` is 0 in the following cycle. RAM contents already written stay as written, and `err` is preserved.
- `start` outside IDLE is ignored.
- A stream that ends short of 512 pixels leaves the block in ACCEPT indefinitely. `busy` stays high and `done` is never produced. Recovery is via `abort` or reset.
- `run_len` wider than the remaining pixels is the only error source.

## Timing

- Reset (reset_n low, asynchronous) sets state IDLE, addr=0, remain=0, color=0, run_ready=0, wr_en=0, wr_row=0, wr_col=0, wr_data=0, busy=0, done=0, err=0.
- `run_ready`, `wr_en`, `busy` and `done` decode from the registered state only. None of them depends combinationally on an input.
- `start` sampled in cycle T leaves `busy` high from T+1 and `run_ready` high from T+1.
- Handshake in cycle T with L>0 produces the first write in T+1 and the last write in T+L. If the image is not yet complete, `run_ready` is high again in T+L+1.
- Throughput: L+1 cycles per nonzero run and 1 cycle per zero run.
- Minimum load time: 512 + (number of nonzero runs) cycles from the first handshake. `done` is high the cycle after the write to address 511. `busy` falls the cycle after `done`.
- RAM write timing: the sprite RAM captures {wr_row, wr_col, wr_data} on the clk edge where `wr_en`=1.

## Test plan

- Two runs, {0x0F0, 256} then {0x000, 256}. Required response: addresses 0–255 written 0x0F0 and 256–511 written 0x000; 514 cycles from the first handshake to `done`; `err`=0.
- `run_valid` toggled randomly with gaps, using the full sprite run list (green/black runs summing to 512). Required response: RAM dump matches the expected image bit-exact; no write occurs while in ACCEPT; exactly one `done`.
- Zero-length run, {0xFFF, 0} inserted between {0x0F0, 300} and {0x000, 212}. Required response: no 0xFFF write; image correct; `done` pulses once.
- Overflow, {0x0F0, 500} then {0x000, 100}. Required response: writes stop at address 511; `err`=1; `done` pulses; no write to address 0 after wrap; `err` clears on the next `start`.
- `abort` at pixel 100 of a 256-pixel run. Required response: `wr_en`=0 the next cycle; state IDLE; `busy`=0. A subsequent full load starts again at address 0.
- reset_n pulsed low mid-WRITE, asynchronously off-edge. Required response: all outputs 0 immediately; `start` ignored while reset_n is low; a later `start` loads correctly.
